// File: rtl/barrel_shifter_4b.sv
// barrel_shifter_4b
//   Registered barrel shifter / rotator built as a log2(WIDTH)-stage mux
//   network. One result per cycle, one cycle of latency, no backpressure.
//
//   Ports
//     clk          rising-edge system clock
//     rst_n        asynchronous active-low reset
//     in_valid     qualifies a / shift_amt / op for capture this cycle
//     a            operand
//     shift_amt    shift distance 0..WIDTH-1
//     op           00 SLL, 01 SRL, 10 SRA, 11 ROL
//     y            registered result
//     out_valid    y carries a fresh result this cycle
//     zero         registered flag, y == 0
//     shifted_out  registered flag, a nonzero bit was discarded

// One output bit of one mux stage. When sel is low the bit passes
// straight through; otherwise the source for the current op is taken.
module barrel_shifter_4b_lane (
  input  logic       sel,
  input  logic [1:0] op,
  input  logic       cur,
  input  logic       sll_src,
  input  logic       srl_src,
  input  logic       sra_src,
  input  logic       rol_src,
  output logic       nxt
);
  always_comb begin
    nxt = cur;
    if (sel) begin
      case (op)
        2'b00:   nxt = sll_src;
        2'b01:   nxt = srl_src;
        2'b10:   nxt = sra_src;
        default: nxt = rol_src;
      endcase
    end
  end
endmodule

module barrel_shifter_4b #(
  parameter  int WIDTH = 4,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   shift_amt,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] y,
  output logic             out_valid,
  output logic             zero,
  output logic             shifted_out
);
  localparam int STAGES = 1;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [SHW-1:0]   amt;
    logic [1:0]       op;
  } req_t;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             so;
  } rsp_t;

  req_t req;
  rsp_t rsp_d, rsp_q;

  assign req = '{a: a, amt: shift_amt, op: op};

  // stg[k] is the data entering stage k; dis[k] accumulates whether any
  // nonzero bit has been pushed off the edge by stages 0..k-1. Because
  // the total shift never reaches WIDTH, the bits each stage drops are
  // always original operand bits, so the running OR equals the OR of the
  // bits the full shift discards.
  logic [SHW:0][WIDTH-1:0] stg;
  logic [SHW:0]            dis;

  assign stg[0] = req.a;
  assign dis[0] = 1'b0;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    localparam int SH = 1 << k;

    logic drop_l, drop_r, drop;

    // Bits a left shift by SH pushes past the MSB / a right shift past the LSB.
    assign drop_l = |stg[k][WIDTH-1 -: SH];
    assign drop_r = |stg[k][SH-1:0];

    always_comb begin
      case (req.op)
        OP_SLL:  drop = drop_l;
        OP_SRL,
        OP_SRA:  drop = drop_r;
        default: drop = 1'b0;   // rotate loses nothing
      endcase
    end

    assign dis[k+1] = dis[k] | (req.amt[k] & drop);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic sll_s, srl_s, sra_s, rol_s;

      if (i >= SH) begin : g_l_in
        assign sll_s = stg[k][i-SH];
      end else begin : g_l_fill
        assign sll_s = 1'b0;
      end

      // Sign for SRA: the MSB of the stage input is already the replicated
      // sign after any earlier stage, so each stage just copies it down.
      if (i + SH < WIDTH) begin : g_r_in
        assign srl_s = stg[k][i+SH];
        assign sra_s = stg[k][i+SH];
      end else begin : g_r_fill
        assign srl_s = 1'b0;
        assign sra_s = stg[k][WIDTH-1];
      end

      assign rol_s = stg[k][(i - SH + WIDTH) % WIDTH];

      barrel_shifter_4b_lane u_lane (
        .sel     (req.amt[k]),
        .op      (req.op),
        .cur     (stg[k][i]),
        .sll_src (sll_s),
        .srl_src (srl_s),
        .sra_src (sra_s),
        .rol_src (rol_s),
        .nxt     (stg[k+1][i])
      );
    end
  end

  assign rsp_d = '{y: stg[SHW], zero: ~|stg[SHW], so: dis[SHW]};

  // Result only loads on in_valid, so junk on the operand inputs during
  // idle cycles never reaches the outputs.
  logic [STAGES:1] vld_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      rsp_q    <= '0;
    end else begin
      vld_pipe <= in_valid;
      if (in_valid) rsp_q <= rsp_d;
    end
  end

  assign y           = rsp_q.y;
  assign zero        = rsp_q.zero;
  assign shifted_out = rsp_q.so;
  assign out_valid   = vld_pipe[STAGES];

endmodule

// File: tb/tb_barrel_shifter_4b.sv
module tb_barrel_shifter_4b;
  localparam logic [1:0] SLL = 2'b00;
  localparam logic [1:0] SRL = 2'b01;
  localparam logic [1:0] SRA = 2'b10;
  localparam logic [1:0] ROL = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a;
  logic [1:0] shift_amt;
  logic [1:0] op;
  logic [3:0] y;
  logic       out_valid, zero, shifted_out;

  int total = 0;
  int bad   = 0;

  // expected register contents
  logic [3:0] e_y;
  logic       e_z, e_so, e_v;

  always #5 clk = ~clk;

  barrel_shifter_4b #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .a           (a),
    .shift_amt   (shift_amt),
    .op          (op),
    .y           (y),
    .out_valid   (out_valid),
    .zero        (zero),
    .shifted_out (shifted_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Arithmetic reference: shifts as multiply/divide by 2^amt.
  function automatic void model(input logic [3:0] ia, input logic [1:0] iamt,
                                input logic [1:0] iop,
                                output logic [3:0] ry, output logic rso);
    int p, full, v, q;
    p = 1 << iamt;
    case (iop)
      SLL: begin
        full = int'(ia) * p;
        ry   = 4'(full % 16);
        rso  = (full / 16) != 0;
      end
      SRL: begin
        ry  = 4'(int'(ia) / p);
        rso = (int'(ia) % p) != 0;
      end
      SRA: begin
        v = (ia >= 4'd8) ? int'(ia) - 16 : int'(ia);
        q = v / p;
        if (v < 0 && (v % p) != 0) q = q - 1;   // floor division
        ry  = 4'(q);
        rso = (v - q * p) != 0;
      end
      default: begin
        full = int'(ia) * p;
        ry   = 4'((full % 16) + (full / 16));
        rso  = 1'b0;
      end
    endcase
  endfunction

  // At a falling edge: check outputs against the expected registers, then
  // drive the next inputs and advance the expectation past the next rise.
  task automatic step(input logic v, input logic [3:0] ia, input logic [1:0] iamt,
                      input logic [1:0] iop);
    logic [3:0] ry;
    logic       rso;
    @(negedge clk);
    chk("out_valid", {31'd0, out_valid}, {31'd0, e_v});
    chk("y", {28'd0, y}, {28'd0, e_y});
    chk("zero", {31'd0, zero}, {31'd0, e_z});
    chk("shifted_out", {31'd0, shifted_out}, {31'd0, e_so});
    in_valid  = v;
    a         = ia;
    shift_amt = iamt;
    op        = iop;
    if (v) begin
      model(ia, iamt, iop, ry, rso);
      e_y  = ry;
      e_z  = (ry == 4'd0);
      e_so = rso;
    end
    e_v = v;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; shift_amt = '0; op = '0;
    e_y = '0; e_z = 1'b0; e_so = 1'b0; e_v = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // directed cases; each constant check looks at the previous issue
    step(1'b1, 4'b1011, 2'd0, SLL);
    step(1'b1, 4'b0001, 2'd1, SLL);
    chk("sll_id_y", {28'd0, y}, 32'hB);
    chk("sll_id_so", {31'd0, shifted_out}, 32'd0);
    step(1'b1, 4'b0011, 2'd2, SLL);
    chk("sll1_y", {28'd0, y}, 32'h2);
    chk("sll1_vld", {31'd0, out_valid}, 32'd1);
    step(1'b1, 4'b1100, 2'd3, SLL);
    chk("sll2_y", {28'd0, y}, 32'hC);
    chk("sll2_so", {31'd0, shifted_out}, 32'd0);
    step(1'b1, 4'b1001, 2'd1, SRL);
    chk("sll_ovf_y", {28'd0, y}, 32'h0);
    chk("sll_ovf_z", {31'd0, zero}, 32'd1);
    chk("sll_ovf_so", {31'd0, shifted_out}, 32'd1);
    step(1'b1, 4'b1001, 2'd1, SRA);
    chk("srl_y", {28'd0, y}, 32'h4);
    chk("srl_so", {31'd0, shifted_out}, 32'd1);
    step(1'b1, 4'b1001, 2'd1, ROL);
    chk("sra_y", {28'd0, y}, 32'hC);
    step(1'b0, 4'($urandom), 2'($urandom), 2'($urandom));
    chk("rol_y", {28'd0, y}, 32'h3);
    chk("rol_so", {31'd0, shifted_out}, 32'd0);

    // hold with idle, toggling inputs
    repeat (6) step(1'b0, 4'($urandom), 2'($urandom), 2'($urandom));
    chk("hold_y", {28'd0, y}, 32'h3);
    chk("hold_vld", {31'd0, out_valid}, 32'd0);

    // asynchronous reset in the middle of a cycle with a live result
    step(1'b1, 4'b0111, 2'd1, SLL);
    step(1'b1, 4'b0101, 2'd0, ROL);
    @(posedge clk);
    #2 rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_y", {28'd0, y}, 32'h0);
    chk("rst_vld", {31'd0, out_valid}, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd0);
    chk("rst_so", {31'd0, shifted_out}, 32'd0);
    e_y = '0; e_z = 1'b0; e_so = 1'b0; e_v = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // full sweep with random idle gaps between issues
    for (int ia = 0; ia < 16; ia++)
      for (int iamt = 0; iamt < 4; iamt++)
        for (int iop = 0; iop < 4; iop++) begin
          step(1'b1, 4'(ia), 2'(iamt), 2'(iop));
          if ($urandom_range(0, 3) == 0)
            step(1'b0, 4'($urandom), 2'($urandom), 2'($urandom));
        end

    // random back-to-back traffic
    repeat (200)
      step(1'($urandom), 4'($urandom), 2'($urandom), 2'($urandom));
    step(1'b0, 4'd0, 2'd0, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/barrel_shifter_4b.md
Name: barrel_shifter_4b

Overview:
Parameterised barrel shifter/rotator with a registered output, default width 4 bits. It is built as a log2(WIDTH)-stage multiplexer network. The default operation is a logical left shift with zero fill. It sits in the datapath as a single-cycle-latency shift unit between operand registers and the result bus, with valid tagging and status flags.

Parameters:
WIDTH, 4, data width in bits; must be a power of two and at least 2.
SHW, log2(WIDTH) = 2, width of the shift-amount field; derived, not overridable.

Ports:
clk  input  1  system clock, all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  qualifies a, shift_amt and op for capture this cycle
a  input  WIDTH  operand to shift
shift_amt  input  SHW  shift distance, 0..WIDTH-1
op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL
y  output  WIDTH  registered shift result
out_valid  output  1  y holds a fresh result
zero  output  1  registered flag, y == 0
shifted_out  output  1  registered flag, a nonzero bit was discarded (SLL/SRL/SRA only)

Behaviour:
- Reset: asserting rst_n low asynchronously clears y, out_valid, zero to 0 and shifted_out to 0. On deassertion the block is idle until the first in_valid.
- Datapath: purely combinational log-shifter with SHW stages. Stage k shifts by 2^k when shift_amt[k]=1, otherwise passes through. No `<<`/`>>` with variable amount; explicit mux stages.
- SLL: y = a shifted left by shift_amt, zeros enter at LSB, bits past MSB discarded.
- SRL: shift right, zeros enter at MSB.
- SRA: shift right, MSB (sign) replicated into vacated bits.
- ROL: rotate left, bits leaving MSB re-enter at LSB; nothing is discarded.
- shift_amt = 0: y = a for every op; shifted_out = 0.
- Latency: one cycle. When in_valid=1 at a rising edge, y, zero and shifted_out load the result of that cycle's inputs, and out_valid=1 on the next cycle.
- When in_valid=0 at an edge: out_valid drops to 0; y, zero and shifted_out hold their previous values.
- Back-to-back in_valid: one result per cycle, no bubbles, no backpressure.
- shifted_out:
  - SLL: OR of the shift_amt MSBs of a that are discarded.
  - SRL: OR of the discarded LSBs.
  - SRA: OR of the discarded LSBs.
  - ROL: always 0.
- zero = (result == 0), registered together with y.
- Reset mid-operation: an in-flight result is discarded and outputs go to their reset values immediately.
- X on inputs while in_valid=0 must not propagate to the outputs.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle -> y=0000, out_valid=0, zero=0, shifted_out=0 without waiting for clk.
- SLL identity: a=1011, amt=0, op=00, in_valid=1 -> next cycle y=1011, out_valid=1, shifted_out=0, zero=0.
- SLL shift 1 and 2:
  - a=0001, amt=1 -> y=0010.
  - a=0011, amt=2 -> y=1100, shifted_out=0.
  - Issue both back-to-back and check the results on consecutive cycles.
- SLL overflow: a=1100, amt=3 -> y=0000, zero=1, shifted_out=1.
- Other ops with a=1001, amt=1:
  - SRL -> y=0100, shifted_out=1.
  - SRA -> y=1100.
  - ROL -> y=0011, shifted_out=0.
- Hold: in_valid=0 after a result -> out_valid=0 and y unchanged while a/amt toggle randomly. Also sweep all 16×4×4 input combinations against a reference model.
